// File: rtl/tone_sequencer.sv
// Purpose: square-wave melody player stepping through a run-time writable note table, one entry per note slot.
// Latency: start/stop/rst act on the next clk_50M edge; every note lasts exactly TICK_CYCLES cycles.
// Backpressure: none; start is ignored while busy and note-table writes are accepted every cycle.
//
// Ports:
//   clk_50M, rst        system clock, synchronous active-high reset
//   wr_en/addr/data     note-table write port, entry = {rest, reload[DIV_W-1:0]}
//   len                 index of the last entry to play, captured on an accepted start
//   start, stop         single-cycle play / abort requests (stop wins if both are high)
//   loop                level; when high at the last slot's end, play wraps back to entry 0
//   speaker             50 % duty square wave, 0 during rests and while idle
//   busy, done          busy while playing; done pulses once when a non-looped play ends
//   note_idx            table index of the entry currently playing
module tone_sequencer #(
    parameter int CLK_DIV     = 10,
    parameter int DIV_W       = 15,
    parameter int TICK_CYCLES = 10_000_000,
    parameter int ADDR_W      = 8
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DIV_W:0]    wr_data,
    input  logic [ADDR_W-1:0] len,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic              speaker,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_idx
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TICK_CYCLES - 1);
    localparam logic [DIV_W-1:0]  TONE_TOP  = '1;
    localparam logic [ADDR_W-1:0] IDX_FIRST = '0;

    typedef struct packed {
        logic             rest;
        logic [DIV_W-1:0] reload;
    } note_t;

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t             state;
    note_t              note_tab [DEPTH];
    note_t              note_q;        // entry captured at the last note load
    note_t              entry_first;
    note_t              entry_next;
    note_t              load_entry;
    logic [ADDR_W-1:0]  len_q;
    logic [ADDR_W-1:0]  idx_next;
    logic [PRE_W-1:0]   pre_cnt;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [DIV_W-1:0]   tone_cnt;
    logic               ce;
    logic               slot_end;
    logic               last_slot;

    // ------------------------------------------------------------------
    // Note table: synchronous write in any state, asynchronous read.
    // Contents survive reset so a tune only has to be loaded once.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50M) begin
        if (wr_en) begin
            note_tab[wr_addr] <= note_t'(wr_data);
        end
    end

    // ------------------------------------------------------------------
    // Free-running prescaler. It is deliberately not realigned at note
    // load, so the first half-period of a note may be up to one ce short.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign ce        = (pre_cnt == PRE_LAST);
    assign slot_end  = (slot_cnt == SLOT_LAST);
    // note_idx never passes len_q, so >= is the same as ==; >= keeps the
    // sequencer from running off if that ever stops being true.
    assign last_slot = (note_idx >= len_q);
    assign idx_next  = note_idx + ADDR_W'(1);

    // Entries are read at the moment of load, so a write to the entry now
    // playing only shows up the next time that entry is loaded.
    always_comb begin
        entry_first = note_tab[IDX_FIRST];
        entry_next  = note_tab[idx_next];
        load_entry  = last_slot ? entry_first : entry_next;
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with the tone generator folded in; all outputs are
    // registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state    <= IDLE;
            speaker  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            note_idx <= '0;
            len_q    <= '0;
            note_q   <= '0;
            tone_cnt <= '0;
            slot_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    speaker <= 1'b0;
                    busy    <= 1'b0;
                    // start together with stop is treated as a cancelled request
                    if (start && !stop) begin
                        state    <= PLAY;
                        busy     <= 1'b1;
                        note_idx <= '0;
                        len_q    <= len;
                        note_q   <= entry_first;
                        tone_cnt <= entry_first.reload;
                        slot_cnt <= '0;
                    end
                end

                PLAY: begin
                    if (stop) begin
                        // abort beats any slot event in the same cycle
                        state   <= IDLE;
                        busy    <= 1'b0;
                        speaker <= 1'b0;
                    end else if (slot_end) begin
                        if (last_slot && !loop) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            speaker <= 1'b0;
                        end else begin
                            // next entry, or wrap to entry 0 in loop mode
                            note_idx <= last_slot ? '0 : idx_next;
                            note_q   <= load_entry;
                            tone_cnt <= load_entry.reload;
                            speaker  <= 1'b0;
                            slot_cnt <= '0;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + SLOT_W'(1);
                        if (note_q.rest) begin
                            speaker  <= 1'b0;
                            tone_cnt <= note_q.reload;
                        end else if (ce) begin
                            // count up to all ones, then reload and flip:
                            // half-period = CLK_DIV * (2^DIV_W - reload)
                            if (tone_cnt == TONE_TOP) begin
                                tone_cnt <= note_q.reload;
                                speaker  <= ~speaker;
                            end else begin
                                tone_cnt <= tone_cnt + DIV_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    speaker <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with CLK_DIV=2, DIV_W=4, TICK_CYCLES=64, ADDR_W=3.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
// Expected half-periods: reload 12 -> 8 cycles, 14 -> 4 cycles, 15 -> 2 cycles, rest -> silent.
module tb_tone_sequencer;

    localparam int CLK_DIV     = 2;
    localparam int DIV_W       = 4;
    localparam int TICK_CYCLES = 64;
    localparam int ADDR_W      = 3;

    logic              clk_50M = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DIV_W:0]    wr_data;
    logic [ADDR_W-1:0] len;
    logic              start;
    logic              stop;
    logic              loop;
    logic              speaker;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] note_idx;

    int total = 0;
    int bad   = 0;

    int tg, gn, gx, hi, dn, idl, ic;

    tone_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .DIV_W      (DIV_W),
        .TICK_CYCLES(TICK_CYCLES),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .speaker (speaker),
        .busy    (busy),
        .done    (done),
        .note_idx(note_idx)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic step(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DIV_W:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Observe n falling edges: speaker toggles and the gaps between them,
    // high samples, done pulses, samples with busy low, note_idx changes.
    task automatic run_slot(input int n, output int tog, output int gmin, output int gmax,
                            output int nhi, output int ndn, output int nidle, output int nchg);
        logic              prev;
        logic [ADDR_W-1:0] idx0;
        int                last;
        prev  = speaker;
        idx0  = note_idx;
        tog   = 0;
        gmin  = 1000;
        gmax  = 0;
        nhi   = 0;
        ndn   = 0;
        nidle = 0;
        nchg  = 0;
        last  = -1;
        for (int i = 1; i <= n; i++) begin
            step(1);
            if (speaker !== prev) begin
                tog++;
                if (last >= 0) begin
                    if (i - last < gmin) gmin = i - last;
                    if (i - last > gmax) gmax = i - last;
                end
                last = i;
                prev = speaker;
            end
            if (speaker === 1'b1) nhi++;
            if (done !== 1'b0) ndn++;
            if (busy !== 1'b1) nidle++;
            if (note_idx !== idx0) nchg++;
        end
    endtask

    // Called at the first sample of a slot (just after its load edge).
    // exp_gap = 0 means a rest slot. Ends at the first sample of the next slot.
    task automatic check_slot(input string tag, input int exp_idx, input int exp_gap, input int min_tog);
        int t, g0, g1, h, d, b, c;
        chk({tag, "_idx"}, note_idx, exp_idx);
        chk({tag, "_spk0"}, speaker, 0);
        chk({tag, "_busy"}, busy, 1);
        run_slot(TICK_CYCLES - 1, t, g0, g1, h, d, b, c);
        if (exp_gap == 0) begin
            chk({tag, "_rest_hi"}, h, 0);
        end else begin
            chk({tag, "_gap_min"}, g0, exp_gap);
            chk({tag, "_gap_max"}, g1, exp_gap);
            chk({tag, "_tog_enough"}, (t >= min_tog), 1);
        end
        chk({tag, "_no_done"}, d, 0);
        chk({tag, "_busy_hold"}, b, 0);
        chk({tag, "_idx_hold"}, c, 0);
        step(1);
    endtask

    // 8-cycle tone, 4-cycle tone, rest, then done with busy falling 192 cycles after start.
    task automatic basic_play(input string tag);
        len  = 3'd2;
        loop = 1'b0;
        pulse_start();
        check_slot({tag, "_s0"}, 0, 8, 7);
        check_slot({tag, "_s1"}, 1, 4, 15);
        check_slot({tag, "_s2"}, 2, 0, 0);
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_end_done"}, done, 1);
        chk({tag, "_end_spk"}, speaker, 0);
        step(1);
        chk({tag, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        len     = '0;
        start   = 1'b0;
        stop    = 1'b0;
        loop    = 1'b0;

        // Reset state
        step(3);
        chk("rst_speaker", speaker, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", note_idx, 0);
        rst = 1'b0;
        step(2);

        // Table: 0 = tone 12, 1 = tone 14, 2 = rest
        wr(3'd0, {1'b0, 4'd12});
        wr(3'd1, {1'b0, 4'd14});
        wr(3'd2, {1'b1, 4'd5});
        step(2);

        // Basic play
        basic_play("basic");
        step(3);

        // Loop: 0,1,2,0,1 then drop loop; play ends after the next index-2 slot
        len  = 3'd2;
        loop = 1'b1;
        pulse_start();
        check_slot("lp0", 0, 8, 7);
        check_slot("lp1", 1, 4, 15);
        check_slot("lp2", 2, 0, 0);
        check_slot("lp3", 0, 8, 7);
        check_slot("lp4", 1, 4, 15);
        loop = 1'b0;
        check_slot("lp5", 2, 0, 0);
        chk("lp_end_busy", busy, 0);
        chk("lp_end_done", done, 1);
        step(3);

        // Stop mid-note, around cycle 100 while the speaker is high
        pulse_start();
        step(96);
        for (int w = 0; w < 8; w++) begin
            if (speaker === 1'b1) break;
            step(1);
        end
        chk("stop_pre_hi", speaker, 1);
        chk("stop_pre_busy", busy, 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_speaker", speaker, 0);
        chk("stop_done", done, 0);
        run_slot(100, tg, gn, gx, hi, dn, idl, ic);
        chk("stop_no_done", dn, 0);
        chk("stop_silent", hi, 0);
        chk("stop_idle", idl, 100);

        // start and stop together while idle
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", busy, 0);
        step(3);
        chk("ss_busy_later", busy, 0);

        // Second start at cycle 30 is ignored
        len = 3'd2;
        pulse_start();
        step(29);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("sb_c30_busy", busy, 1);
        chk("sb_c30_idx", note_idx, 0);
        step(33);
        chk("sb_c63_idx", note_idx, 0);
        step(1);
        chk("sb_c64_idx", note_idx, 1);
        chk("sb_c64_busy", busy, 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("sb_stop_busy", busy, 0);
        step(3);

        // Reset at cycle 70, then replay without rewriting the table
        pulse_start();
        check_slot("rs0", 0, 8, 7);
        chk("rs_c64_idx", note_idx, 1);
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rs_speaker", speaker, 0);
        chk("rs_busy", busy, 0);
        chk("rs_done", done, 0);
        chk("rs_idx", note_idx, 0);
        step(3);
        basic_play("replay");
        step(3);

        // len = 0 plays a single slot
        len  = 3'd0;
        loop = 1'b0;
        pulse_start();
        check_slot("z0", 0, 8, 7);
        chk("z_end_busy", busy, 0);
        chk("z_end_done", done, 1);
        step(3);

        // Live write of entry 0 during slot 1; next index-0 slot is max pitch
        len  = 3'd2;
        loop = 1'b1;
        pulse_start();
        check_slot("lw0", 0, 8, 7);
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = {1'b0, 4'd15};
        check_slot("lw1", 1, 4, 15);
        wr_en = 1'b0;
        check_slot("lw2", 2, 0, 0);
        check_slot("lw3", 0, 2, 30);
        stop = 1'b1;
        loop = 1'b0;
        step(1);
        stop = 1'b0;
        chk("lw_stop_busy", busy, 0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
